mult_hazard_ctrl: RTL and testbench

MULT_HAZARD_CTRL -- requirements
Module: mult_hazard_ctrl

---
 rtl/mult_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_mult_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hazard_ctrl.sv
// Multiply-latency hazard controller: sequences a fixed-latency multiplier and
// drives stall/forwarding. Define MULT_HAZARD_CTRL_FWD_EN to enable operand forwarding.
module mult_hazard_ctrl #(
    parameter int MULT_LAT   = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  id_valid,
    input  logic                  id_is_mult,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    output logic                  stall,
    output logic                  mult_start,
    output logic                  mult_done,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [REG_ADDR_W-1:0] busy_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MULT_LAT - 2);

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic [REG_ADDR_W-1:0]   busy_rd_nxt;
    logic [1:0]              fwd_a_nxt, fwd_b_nxt;
    logic                    raw_hazard;
    logic                    accept;

    // A pipeline stage "hits" a source when it writes a nonzero register equal to it.
    function automatic logic hits(input logic [REG_ADDR_W-1:0] rd,
                                  input logic                  wr,
                                  input logic [REG_ADDR_W-1:0] rs);
        return wr && (rd != '0) && (rd == rs);
    endfunction

`ifdef MULT_HAZARD_CTRL_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        if (hits(ex_rd, ex_reg_write, rs))        return 2'd1;
        else if (hits(mem_rd, mem_reg_write, rs)) return 2'd2;
        else                                      return 2'd0;
    endfunction

    assign raw_hazard = 1'b0;
`else
    // Without forwarding, any read of an in-flight EX/MEM result must wait.
    assign raw_hazard = hits(ex_rd,  ex_reg_write,  id_rs1) | hits(ex_rd,  ex_reg_write,  id_rs2) |
                        hits(mem_rd, mem_reg_write, id_rs1) | hits(mem_rd, mem_reg_write, id_rs2);
`endif

    assign stall  = id_valid && ((state == MULT) || raw_hazard);
    assign accept = id_valid && id_is_mult && !stall && (state != MULT);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt   = state;
        cnt_nxt     = cnt;
        busy_rd_nxt = busy_rd;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = MULT;
                    cnt_nxt     = CNT_LOAD;
                    busy_rd_nxt = id_rd;
                end
            end
            MULT: begin
                if (cnt == 4'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            DONE: begin
                if (accept) begin
                    state_nxt   = MULT;
                    cnt_nxt     = CNT_LOAD;
                    busy_rd_nxt = id_rd;
                end else begin
                    state_nxt   = IDLE;
                    busy_rd_nxt = '0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = 4'd0;
                busy_rd_nxt = '0;
            end
        endcase
    end

    always_comb begin
        fwd_a_nxt = 2'd0;
        fwd_b_nxt = 2'd0;
`ifdef MULT_HAZARD_CTRL_FWD_EN
        // A stalled edge injects a bubble into EX, so it must read the register file.
        if (!stall) begin
            fwd_a_nxt = fwd_sel(id_rs1);
            fwd_b_nxt = fwd_sel(id_rs2);
        end
`endif
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            busy_rd    <= '0;
            mult_start <= 1'b0;
            mult_done  <= 1'b0;
            fwd_a      <= 2'd0;
            fwd_b      <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            busy_rd    <= busy_rd_nxt;
            mult_start <= accept;
            mult_done  <= (state == DONE);
            fwd_a      <= fwd_a_nxt;
            fwd_b      <= fwd_b_nxt;
        end
    end

endmodule

// File: tb/tb_mult_hazard_ctrl.sv
// Self-checking bench for mult_hazard_ctrl: timeline model of accepted multiplies
// plus directed literal checks; honours MULT_HAZARD_CTRL_FWD_EN.
module tb_mult_hazard_ctrl;

    localparam int LAT = 4;
    localparam int AW  = 5;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          id_valid, id_is_mult;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, ex_rd, mem_rd;
    logic          ex_reg_write, mem_reg_write;
    logic          stall, mult_start, mult_done;
    logic [1:0]    fwd_a, fwd_b;
    logic [AW-1:0] busy_rd;

    mult_hazard_ctrl #(.MULT_LAT(LAT), .REG_ADDR_W(AW)) dut (
        .clk(clk), .arst_n(arst_n),
        .id_valid(id_valid), .id_is_mult(id_is_mult),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .stall(stall), .mult_start(mult_start), .mult_done(mult_done),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .busy_rd(busy_rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: each accepted multiply at cycle a owns the window a+1..a+LAT
    // (busy), stalls ID during a+1..a+LAT-1, and produces done at a+LAT+1.
    int            cyc = 0;
    bit            have_a = 1'b0;
    int            last_a = 0;
    logic [AW-1:0] last_rd = '0;
    int            done_q[$];
    logic [1:0]    exp_fa = 2'd0, exp_fb = 2'd0;
    bit            m_st;

    function automatic bit hit(input logic [AW-1:0] rd, input logic wr, input logic [AW-1:0] rs);
        return wr && (rd != 0) && (rd == rs);
    endfunction

    function automatic bit model_stall(input int c);
        bit in_mult;
        bit raw;
        in_mult = have_a && (c >= last_a + 1) && (c <= last_a + LAT - 1);
        raw = 1'b0;
`ifndef MULT_HAZARD_CTRL_FWD_EN
        raw = hit(ex_rd, ex_reg_write, id_rs1)  || hit(ex_rd, ex_reg_write, id_rs2) ||
              hit(mem_rd, mem_reg_write, id_rs1) || hit(mem_rd, mem_reg_write, id_rs2);
`endif
        return id_valid && (in_mult || raw);
    endfunction

    function automatic logic [1:0] model_fwd(input logic [AW-1:0] rs);
        if (hit(ex_rd, ex_reg_write, rs))   return 2'd1;
        if (hit(mem_rd, mem_reg_write, rs)) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            have_a = 1'b0;
            done_q.delete();
            exp_fa = 2'd0;
            exp_fb = 2'd0;
        end else begin
            m_st = model_stall(cyc);
            if (id_valid && id_is_mult && !m_st) begin
                have_a  = 1'b1;
                last_a  = cyc;
                last_rd = id_rd;
                done_q.push_back(cyc + LAT + 1);
            end
`ifdef MULT_HAZARD_CTRL_FWD_EN
            exp_fa = m_st ? 2'd0 : model_fwd(id_rs1);
            exp_fb = m_st ? 2'd0 : model_fwd(id_rs2);
`else
            exp_fa = 2'd0;
            exp_fb = 2'd0;
`endif
            cyc++;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic [AW-1:0] e_busy;
        bit            e_done;
        bit            e_start;
        e_start = have_a && (last_a == cyc - 1);
        e_busy  = (have_a && cyc >= last_a + 1 && cyc <= last_a + LAT) ? last_rd : '0;
        e_done  = 1'b0;
        foreach (done_q[i]) if (done_q[i] == cyc) e_done = 1'b1;
        check("stall",      32'(stall),      32'(model_stall(cyc)));
        check("mult_start", 32'(mult_start), 32'(e_start));
        check("mult_done",  32'(mult_done),  32'(e_done));
        check("busy_rd",    32'(busy_rd),    32'(e_busy));
        check("fwd_a",      32'(fwd_a),      32'(exp_fa));
        check("fwd_b",      32'(fwd_b),      32'(exp_fb));
    end

    task automatic drive(input logic v, input logic m, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic [AW-1:0] exr, input logic exw,
                         input logic [AW-1:0] memr, input logic memw);
        id_valid = v;  id_is_mult = m;
        id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;
        ex_rd = exr;   ex_reg_write = exw;
        mem_rd = memr; mem_reg_write = memw;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 32'(mult_start), 0);
        check({tag, "_done"},  32'(mult_done),  0);
        check({tag, "_busy"},  32'(busy_rd),    0);
        check({tag, "_fwd_a"}, 32'(fwd_a),      0);
        check({tag, "_fwd_b"}, 32'(fwd_b),      0);
        check({tag, "_stall"}, 32'(stall),      0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int dcount;

    initial begin
        idle_in();
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        mid();
        check_all_zero("reset");
        arst_n = 1'b1;

        // Single multiply, rd=5, accepted on the first edge after reset.
        drive(1'b1, 1'b1, 5'd1, 5'd2, 5'd5, '0, 1'b0, '0, 1'b0);
        next_cyc();
        idle_in();
        mid();
        check("single_start_c1", 32'(mult_start), 1);
        check("single_busy_c1",  32'(busy_rd),    5);
        for (int k = 2; k <= 4; k++) begin
            next_cyc(); mid();
            check("single_start_off", 32'(mult_start), 0);
            check("single_busy_held", 32'(busy_rd),    5);
            check("single_done_early",32'(mult_done),  0);
        end
        next_cyc(); mid();
        check("single_done_c5", 32'(mult_done), 1);
        next_cyc(); mid();
        check("single_done_c6", 32'(mult_done), 0);
        check("single_busy_c6", 32'(busy_rd),   0);

        // Back-to-back: second multiply waits in ID, accepted in DONE.
        next_cyc();
        drive(1'b1, 1'b1, 5'd3, 5'd4, 5'd6, '0, 1'b0, '0, 1'b0);
        next_cyc();
        drive(1'b1, 1'b1, 5'd1, 5'd2, 5'd9, '0, 1'b0, '0, 1'b0);
        mid(); check("b2b_stall_c1", 32'(stall), 1);
        next_cyc(); mid(); check("b2b_stall_c2", 32'(stall), 1);
        next_cyc(); mid(); check("b2b_stall_c3", 32'(stall), 1);
        next_cyc(); mid(); check("b2b_stall_done", 32'(stall), 0);
        check("b2b_busy_done", 32'(busy_rd), 6);
        next_cyc();
        idle_in();
        mid();
        check("b2b_start2", 32'(mult_start), 1);
        check("b2b_done1",  32'(mult_done),  1);
        check("b2b_busy2",  32'(busy_rd),    9);
        repeat (LAT + 1) next_cyc();

`ifndef MULT_HAZARD_CTRL_FWD_EN
        drive(1'b1, 1'b0, 5'd4, 5'd1, 5'd8, 5'd4, 1'b1, '0, 1'b0);
        mid(); check("raw_ex_stall", 32'(stall), 1);
        next_cyc(); mid(); check("raw_ex_fwd_a", 32'(fwd_a), 0);
        drive(1'b1, 1'b0, 5'd1, 5'd7, 5'd8, '0, 1'b0, 5'd7, 1'b1);
        mid(); check("raw_mem_stall", 32'(stall), 1);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd8, 5'd0, 1'b1, 5'd0, 1'b1);
        mid(); check("raw_r0_stall", 32'(stall), 0);
        drive(1'b1, 1'b0, 5'd4, 5'd0, 5'd8, 5'd4, 1'b0, '0, 1'b0);
        mid(); check("raw_nowrite_stall", 32'(stall), 0);
        drive(1'b0, 1'b0, 5'd4, 5'd4, 5'd0, 5'd4, 1'b1, 5'd4, 1'b1);
        mid(); check("raw_invalid_stall", 32'(stall), 0);
        next_cyc();
        drive(1'b1, 1'b1, 5'd4, 5'd0, 5'd10, 5'd4, 1'b1, '0, 1'b0);
        next_cyc();
        idle_in();
        mid();
        check("raw_mult_blocked_start", 32'(mult_start), 0);
        check("raw_mult_blocked_busy",  32'(busy_rd),    0);
`else
        drive(1'b1, 1'b0, 5'd3, 5'd0, 5'd8, 5'd3, 1'b1, 5'd3, 1'b1);
        next_cyc(); mid();
        check("fwd_prio_a", 32'(fwd_a), 1);
        check("fwd_prio_b", 32'(fwd_b), 0);
        drive(1'b1, 1'b0, 5'd1, 5'd7, 5'd8, '0, 1'b0, 5'd7, 1'b1);
        next_cyc(); mid();
        check("fwd_mem_b", 32'(fwd_b), 2);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd8, 5'd0, 1'b1, 5'd0, 1'b1);
        next_cyc(); mid();
        check("fwd_r0_a", 32'(fwd_a), 0);
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd13, '0, 1'b0, '0, 1'b0);
        next_cyc();
        drive(1'b1, 1'b0, 5'd3, 5'd3, 5'd8, 5'd3, 1'b1, 5'd3, 1'b1);
        mid(); check("fwd_bubble_stall", 32'(stall), 1);
        next_cyc(); mid();
        check("fwd_bubble_a", 32'(fwd_a), 0);
        check("fwd_bubble_b", 32'(fwd_b), 0);
        idle_in();
        repeat (LAT + 1) next_cyc();
`endif

        // Reset two cycles after mult_start abandons the multiply.
        idle_in();
        next_cyc();
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd11, '0, 1'b0, '0, 1'b0);
        next_cyc();
        idle_in();
        next_cyc();
        next_cyc();
        mid();
        check("rst_mult_busy_before", 32'(busy_rd), 11);
        arst_n = 1'b0;
        #1;
        check_all_zero("rst_mult");
        next_cyc(); mid();
        arst_n = 1'b1;
        dcount = 0;
        repeat (8) begin
            next_cyc(); mid();
            if (mult_done) dcount++;
        end
        check("rst_mult_no_done", 32'(dcount), 0);

        // Reset while in DONE suppresses the pending done pulse.
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd12, '0, 1'b0, '0, 1'b0);
        next_cyc();
        idle_in();
        repeat (LAT - 1) next_cyc();
        mid();
        check("rst_done_busy_before", 32'(busy_rd), 12);
        arst_n = 1'b0;
        #1;
        check_all_zero("rst_done");
        next_cyc(); mid();
        arst_n = 1'b1;
        dcount = 0;
        repeat (4) begin
            next_cyc(); mid();
            if (mult_done) dcount++;
        end
        check("rst_done_no_done", 32'(dcount), 0);

        // Mixed traffic over a small register set, checked by the model.
        next_cyc();
        repeat (300) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3),
                  AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 31)),
                  AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            next_cyc();
        end
        idle_in();
        repeat (LAT + 3) next_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
